// File: rtl/bus_initiator.sv
// bus_initiator: 32-bit big-endian bus master for byte/word/long loads and stores.
// Define BUS_INITIATOR_MISALIGNED_SPLIT_EN to allow misaligned accesses (split in two bus cycles).
module bus_initiator (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] resp_data,
    output logic        bus_cs,
    output logic [29:0] bus_address,
    output logic [31:0] bus_data_out,
    input  logic [31:0] bus_data_in,
    output logic [3:0]  bus_data_strobes,
    output logic        bus_read,
    output logic        bus_write
);
`ifdef BUS_INITIATOR_MISALIGNED_SPLIT_EN
    localparam int NB = 8;
`else
    localparam int NB = 4;
`endif
    localparam int WW = NB * 8;

    typedef enum logic [1:0] {IDLE, ACCESS1, ACCESS2} state_t;

    state_t          state;
    logic [1:0]      sz_q;
    logic            sgn_q;
    logic            wr_q;
    logic [2:0]      sh_q;
    logic [3:0]      nb;
    logic [2:0]      sh;
    logic [NB-1:0]   stb;
    logic [WW-1:0]   wd;
    logic [WW-1:0]   win;
    logic [31:0]     v;
    logic [31:0]     load_val;
    logic            legal;
`ifdef BUS_INITIATOR_MISALIGNED_SPLIT_EN
    logic            split_q;
    logic [3:0]      stb2_q;
    logic [31:0]     wd2_q;
    logic [31:0]     rd_hi;
`endif

    // The access is viewed as a window of NB bytes, byte 0 at the top; sh is the
    // distance in bytes from the last accessed byte to the bottom of the window.
    always_comb begin
        nb = req_size == 2'b00 ? 4'd1 : req_size == 2'b01 ? 4'd2 : 4'd4;
        sh = 3'(4'(NB) - {2'b00, req_addr[1:0]} - nb);
        stb = NB'(req_size == 2'b00 ? 4'b0001 : req_size == 2'b01 ? 4'b0011 : 4'b1111) << sh;
        wd = WW'(req_write ? req_data & (req_size == 2'b00 ? 32'hFF : req_size == 2'b01 ? 32'hFFFF : 32'hFFFF_FFFF) : 32'h0) << {sh, 3'b000};
`ifdef BUS_INITIATOR_MISALIGNED_SPLIT_EN
        legal = req_size != 2'b11;
        win = state == ACCESS2 ? {rd_hi, bus_data_in} : {bus_data_in, 32'h0};
`else
        legal = req_size == 2'b00 || (req_size == 2'b01 && !req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] == 2'b00);
        win = bus_data_in;
`endif
        v = 32'(win >> {sh_q, 3'b000});
        load_val = sz_q == 2'b00 ? {{24{sgn_q & v[7]}}, v[7:0]} :
                   sz_q == 2'b01 ? {{16{sgn_q & v[15]}}, v[15:0]} : v;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            resp_data <= '0;
            bus_cs <= 1'b0;
            bus_address <= '0;
            bus_data_out <= '0;
            bus_data_strobes <= '0;
            bus_read <= 1'b0;
            bus_write <= 1'b0;
            sz_q <= '0;
            sgn_q <= 1'b0;
            wr_q <= 1'b0;
            sh_q <= '0;
`ifdef BUS_INITIATOR_MISALIGNED_SPLIT_EN
            split_q <= 1'b0;
            stb2_q <= '0;
            wd2_q <= '0;
            rd_hi <= '0;
`endif
        end else begin
            done <= 1'b0;
            error <= 1'b0;
            if (state == IDLE) begin
                if (req) begin
                    sz_q <= req_size;
                    sgn_q <= req_signed;
                    wr_q <= req_write;
                    sh_q <= sh;
                    if (!legal) begin
                        done <= 1'b1;
                        error <= 1'b1;
                    end else begin
                        state <= ACCESS1;
                        busy <= 1'b1;
                        bus_cs <= 1'b1;
                        bus_read <= !req_write;
                        bus_write <= req_write;
                        bus_address <= req_addr[31:2];
                        bus_data_strobes <= stb[NB-1 -: 4];
                        bus_data_out <= wd[WW-1 -: 32];
`ifdef BUS_INITIATOR_MISALIGNED_SPLIT_EN
                        split_q <= |stb[3:0];
                        stb2_q <= stb[3:0];
                        wd2_q <= wd[31:0];
`endif
                    end
                end
            end else begin
`ifdef BUS_INITIATOR_MISALIGNED_SPLIT_EN
                if (state == ACCESS1 && split_q) begin
                    state <= ACCESS2;
                    rd_hi <= bus_data_in;
                    bus_address <= bus_address + 30'd1;
                    bus_data_strobes <= stb2_q;
                    bus_data_out <= wd2_q;
                end else
`endif
                begin
                    state <= IDLE;
                    busy <= 1'b0;
                    bus_cs <= 1'b0;
                    bus_read <= 1'b0;
                    bus_write <= 1'b0;
                    bus_data_strobes <= '0;
                    done <= 1'b1;
                    if (!wr_q)
                        resp_data <= load_val;
                end
            end
        end
    end
endmodule
